cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 144 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding entry per functional-unit requester,
// up to four entries broadcast per cycle on packed lanes, round-robin order.
module cdb_arbiter #(
    parameter int NUM_REQ = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [4*NUM_REQ-1:0]    req_rob_index,
    input  logic [16*NUM_REQ-1:0]   req_result,
    output logic [NUM_REQ-1:0]      req_busy,
    output logic [3:0]              cdb_valid,
    output logic [15:0]             cdb_rob_index,
    output logic [63:0]             cdb_result,
    output logic                    drop_err
);

    localparam int PTR_W     = $clog2(NUM_REQ);
    localparam int NUM_LANES = 4;

    logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
    logic [3:0]         hold_tag_q    [NUM_REQ];
    logic [3:0]         hold_tag_d    [NUM_REQ];
    logic [15:0]        hold_result_q [NUM_REQ];
    logic [15:0]        hold_result_d [NUM_REQ];
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]         cdb_valid_q, cdb_valid_d;
    logic [15:0]        cdb_rob_index_q, cdb_rob_index_d;
    logic [63:0]        cdb_result_q, cdb_result_d;
    logic               drop_err_q, drop_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [NUM_LANES-1:0] lane_used;
    logic [PTR_W-1:0]   lane_src [NUM_LANES];
    logic [PTR_W-1:0]   last_grant;
    logic [2:0]         grant_cnt;
    logic [3:0]         scan_sum;
    logic [PTR_W-1:0]   scan_idx;
    logic [NUM_REQ-1:0] capture;

    // Circular scan from rr_ptr, handing the first four held entries to lanes 0..3 in order
    always_comb begin
        grant      = '0;
        lane_used  = '0;
        last_grant = '0;
        grant_cnt  = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_src[k] = '0;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            scan_sum = 4'(rr_ptr_q) + 4'(j);
            if (scan_sum >= 4'(NUM_REQ)) begin
                scan_sum = scan_sum - 4'(NUM_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (hold_valid_q[scan_idx] && (grant_cnt < 3'd4)) begin
                grant[scan_idx]           = 1'b1;
                lane_used[grant_cnt[1:0]] = 1'b1;
                lane_src[grant_cnt[1:0]]  = scan_idx;
                last_grant                = scan_idx;
                grant_cnt                 = grant_cnt + 3'd1;
            end
        end
    end

    // A granted entry drains this edge, so it is free to accept a refill
    assign req_busy = hold_valid_q & ~grant;
    assign capture  = req_valid & ~req_busy & {NUM_REQ{~flush}};

    // Next-state for holding entries, round-robin pointer, lanes and drop flag
    always_comb begin
        hold_valid_d = hold_valid_q & ~grant;
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_tag_d[i]    = hold_tag_q[i];
            hold_result_d[i] = hold_result_q[i];
            if (capture[i]) begin
                hold_valid_d[i]  = 1'b1;
                hold_tag_d[i]    = req_rob_index[4*i +: 4];
                hold_result_d[i] = req_result[16*i +: 16];
            end
        end
        if (flush) begin
            hold_valid_d = '0;
        end

        rr_ptr_d = rr_ptr_q;
        if ((|grant) && !flush) begin
            if (last_grant == PTR_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = last_grant + 1'b1;
            end
        end

        cdb_valid_d     = '0;
        cdb_rob_index_d = '0;
        cdb_result_d    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_used[k] && !flush) begin
                cdb_valid_d[k]            = 1'b1;
                cdb_rob_index_d[4*k +: 4] = hold_tag_q[lane_src[k]];
                cdb_result_d[16*k +: 16]  = hold_result_q[lane_src[k]];
            end
        end

        drop_err_d = drop_err_q | ((|(req_valid & req_busy)) & ~flush);
    end

    // Control and broadcast state, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q    <= '0;
            rr_ptr_q        <= '0;
            cdb_valid_q     <= '0;
            cdb_rob_index_q <= '0;
            cdb_result_q    <= '0;
            drop_err_q      <= 1'b0;
        end else begin
            hold_valid_q    <= hold_valid_d;
            rr_ptr_q        <= rr_ptr_d;
            cdb_valid_q     <= cdb_valid_d;
            cdb_rob_index_q <= cdb_rob_index_d;
            cdb_result_q    <= cdb_result_d;
            drop_err_q      <= drop_err_d;
        end
    end

    // Payload storage needs no reset; it is only observed behind hold_valid
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            hold_tag_q[i]    <= hold_tag_d[i];
            hold_result_q[i] <= hold_result_d[i];
        end
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_rob_index = cdb_rob_index_q;
    assign cdb_result    = cdb_result_q;
    assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (NUM_REQ=6): stimulus pushes expected
// broadcast beats, an independent monitor pops and compares each valid beat.
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  req_valid;
    logic [23:0] req_rob_index;
    logic [95:0] req_result;
    logic [5:0]  req_busy;
    logic [3:0]  cdb_valid;
    logic [15:0] cdb_rob_index;
    logic [63:0] cdb_result;
    logic        drop_err;

    typedef struct packed {
        logic [3:0]  v;
        logic [15:0] idx;
        logic [63:0] res;
    } beat_t;

    beat_t expQ[$];
    int    compares    = 0;
    int    miscompares = 0;

    cdb_arbiter #(.NUM_REQ(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .req_valid     (req_valid),
        .req_rob_index (req_rob_index),
        .req_result    (req_result),
        .req_busy      (req_busy),
        .cdb_valid     (cdb_valid),
        .cdb_rob_index (cdb_rob_index),
        .cdb_result    (cdb_result),
        .drop_err      (drop_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the stimulus and monitor processes
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compares++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of requester inputs on the falling edge
    task automatic applyStimulus(input logic [5:0] vld, input logic [23:0] tags,
                                 input logic [95:0] res, input logic fl);
        @(negedge clk);
        req_valid     = vld;
        req_rob_index = tags;
        req_result    = res;
        flush         = fl;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            applyStimulus(6'b0, 24'h0, 96'h0, 1'b0);
        end
    endtask

    task automatic pushBeat(input logic [3:0] v, input logic [15:0] idx, input logic [63:0] res);
        beat_t b;
        b.v   = v;
        b.idx = idx;
        b.res = res;
        expQ.push_back(b);
    endtask

    task automatic checkQuiet(input string name);
        checkOutput({name, "_cdb_valid"}, 64'(cdb_valid), 64'h0);
        checkOutput({name, "_cdb_rob_index"}, 64'(cdb_rob_index), 64'h0);
        checkOutput({name, "_cdb_result"}, cdb_result, 64'h0);
        checkOutput({name, "_req_busy"}, 64'(req_busy), 64'h0);
    endtask

    // Monitor: every non-empty broadcast must match the oldest expected beat
    initial begin
        beat_t b;
        forever begin
            @(posedge clk);
            #1;
            if (cdb_valid !== 4'b0) begin
                if (expQ.size() == 0) begin
                    compares++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_beat: got valid=%0h tags=%0h res=%0h, expected no broadcast",
                             cdb_valid, cdb_rob_index, cdb_result);
                end else begin
                    b = expQ.pop_front();
                    checkOutput("beat_valid", 64'(cdb_valid), 64'(b.v));
                    checkOutput("beat_tags", 64'(cdb_rob_index), 64'(b.idx));
                    checkOutput("beat_result", cdb_result, b.res);
                end
            end
        end
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_rob_index = '0; req_result = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkQuiet("reset");
        checkOutput("reset_drop_err", 64'(drop_err), 64'h0);

        // Single request on requester 2, rr_ptr moves to 3
        $display("[TB] single request");
        pushBeat(4'b0001, 16'h0005, 64'h0000_0000_0000_1234);
        applyStimulus(6'b000100, 24'h000500, 96'h0000_0000_0000_1234_0000_0000, 1'b0);
        idle(1);
        #1 checkOutput("single_busy", 64'(req_busy), 64'h0);
        idle(2);

        // Six at once starting from rr_ptr=3: lanes get 3,4,5,0 then 1,2
        $display("[TB] six requests from rr_ptr 3");
        pushBeat(4'b1111, 16'h0543, 64'hA000_A005_A004_A003);
        pushBeat(4'b0011, 16'h0021, 64'h0000_0000_A002_A001);
        applyStimulus(6'b111111, 24'h543210, 96'hA005_A004_A003_A002_A001_A000, 1'b0);
        #1 checkOutput("six_rr3_busy_pre", 64'(req_busy), 64'h0);
        idle(1);
        #1 checkOutput("six_rr3_busy", 64'(req_busy), 64'h06);
        idle(3);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1 checkQuiet("reset2");

        // Six at once from rr_ptr=0: lanes get 0..3 then 4,5
        $display("[TB] six requests from rr_ptr 0");
        pushBeat(4'b1111, 16'h3210, 64'hB003_B002_B001_B000);
        pushBeat(4'b0011, 16'h0054, 64'h0000_0000_B005_B004);
        applyStimulus(6'b111111, 24'h543210, 96'hB005_B004_B003_B002_B001_B000, 1'b0);
        idle(1);
        #1 checkOutput("six_rr0_busy", 64'(req_busy), 64'h30);
        idle(3);

        // Requesters 0 and 5 stream every cycle without ever going busy
        $display("[TB] fairness stream");
        for (int t = 0; t < 4; t++) begin
            pushBeat(4'b0011, {8'h00, 4'(8 + t), 4'(t)},
                     {32'h0, 16'hC500 + 16'(t), 16'hC000 + 16'(t)});
            applyStimulus(6'b100001, {4'(8 + t), 16'h0, 4'(t)},
                          {16'hC500 + 16'(t), 64'h0, 16'hC000 + 16'(t)}, 1'b0);
            #1 checkOutput("stream_busy", 64'(req_busy), 64'h0);
        end
        idle(3);

        // Move rr_ptr to 2, then fill all six so requester 1 waits last and drops tag 9
        $display("[TB] drop while busy");
        pushBeat(4'b0001, 16'h0007, 64'h0000_0000_0000_D107);
        applyStimulus(6'b000010, 24'h000070, 96'h0000_0000_0000_0000_D107_0000, 1'b0);
        idle(2);
        pushBeat(4'b1111, 16'h5432, 64'hD005_D004_D003_D002);
        pushBeat(4'b0011, 16'h0010, 64'h0000_0000_D001_D000);
        applyStimulus(6'b111111, 24'h543210, 96'hD005_D004_D003_D002_D001_D000, 1'b0);
        applyStimulus(6'b000010, 24'h000090, 96'h0000_0000_0000_0000_DEAD_0000, 1'b0);
        #1 checkOutput("drop_busy", 64'(req_busy), 64'h03);
        idle(1);
        #1 checkOutput("drop_err_set", 64'(drop_err), 64'h1);
        idle(3);

        // Flush with six held: nothing broadcast, buffers empty, rr_ptr stays at 2
        $display("[TB] flush");
        applyStimulus(6'b111111, 24'h543210, 96'hE005_E004_E003_E002_E001_E000, 1'b0);
        applyStimulus(6'b0, 24'h0, 96'h0, 1'b1);
        idle(1);
        #1 checkQuiet("flush");
        checkOutput("flush_drop_err", 64'(drop_err), 64'h1);
        idle(3);
        pushBeat(4'b0011, 16'h00AB, 64'h0000_0000_F000_F003);
        applyStimulus(6'b001001, 24'h00B00A, 96'h0000_0000_F003_0000_0000_F000, 1'b0);
        idle(3);

        // Reset while three lanes are live; the next wave must never appear
        $display("[TB] reset mid-burst");
        pushBeat(4'b0111, 16'h0132, 64'h0000_1000_1002_1001);
        applyStimulus(6'b000111, 24'h000321, 96'h0000_0000_0000_1002_1001_1000, 1'b0);
        applyStimulus(6'b111000, 24'h654000, 96'h1005_1004_1003_0000_0000_0000, 1'b0);
        #1 checkOutput("burst_busy", 64'(req_busy), 64'h0);
        @(negedge clk);
        req_valid = '0; req_rob_index = '0; req_result = '0;
        rst = 1'b1;
        #1 checkOutput("burst_lanes", 64'(cdb_valid), 64'h7);
        @(negedge clk);
        rst = 1'b0;
        #1 checkQuiet("midreset");
        checkOutput("midreset_drop_err", 64'(drop_err), 64'h0);
        idle(3);
        pushBeat(4'b0011, 16'h00BA, 64'h0000_0000_F003_F000);
        applyStimulus(6'b001001, 24'h00B00A, 96'h0000_0000_F003_0000_0000_F000, 1'b0);
        idle(4);

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", compares, miscompares);
        $finish;
    end

endmodule
